// File: rtl/xpt_sequencer_if.sv
// ---------------------------------------------------------------------------
// xpt_sequencer_if
// Bundle of the signals between the CPU core and the exception / bus-request
// sequencer.
//   master : core side. It drives the request, strobe and done inputs and
//            receives the grant, acknowledge, push, vector and jump outputs.
//   slave  : sequencer side, with the directions reversed.
// Signals:
//   boundary, BUSRQ, NMI, INT, IM[1:0], Ireg[7:0]          core -> sequencer
//   ei_exec, di_exec, retn_exec, halt_exec                  decode strobes
//   ack_done, Din[7:0], push_done, vec_done, vec_data[15:0] bus-cycle completions
//   BUSAK, INTACK, push_req, vec_req, vec_addr[15:0]        sequencer requests
//   jump, jump_addr[15:0], exec_op, op_byte[7:0]            PC / opcode control
//   IFF1, IFF2, HALT, busy                                  flag and status
// ---------------------------------------------------------------------------
interface xpt_sequencer_if;
  logic        boundary;
  logic        BUSRQ;
  logic        NMI;
  logic        INT;
  logic [1:0]  IM;
  logic [7:0]  Ireg;
  logic        ei_exec;
  logic        di_exec;
  logic        retn_exec;
  logic        halt_exec;
  logic        ack_done;
  logic [7:0]  Din;
  logic        push_done;
  logic        vec_done;
  logic [15:0] vec_data;
  logic        BUSAK;
  logic        INTACK;
  logic        push_req;
  logic        vec_req;
  logic [15:0] vec_addr;
  logic        jump;
  logic [15:0] jump_addr;
  logic        exec_op;
  logic [7:0]  op_byte;
  logic        IFF1;
  logic        IFF2;
  logic        HALT;
  logic        busy;

  modport master (
    output boundary, BUSRQ, NMI, INT, IM, Ireg,
    output ei_exec, di_exec, retn_exec, halt_exec,
    output ack_done, Din, push_done, vec_done, vec_data,
    input  BUSAK, INTACK, push_req, vec_req, vec_addr,
    input  jump, jump_addr, exec_op, op_byte,
    input  IFF1, IFF2, HALT, busy
  );

  modport slave (
    input  boundary, BUSRQ, NMI, INT, IM, Ireg,
    input  ei_exec, di_exec, retn_exec, halt_exec,
    input  ack_done, Din, push_done, vec_done, vec_data,
    output BUSAK, INTACK, push_req, vec_req, vec_addr,
    output jump, jump_addr, exec_op, op_byte,
    output IFF1, IFF2, HALT, busy
  );
endinterface

// File: rtl/xpt_sequencer.sv
// ---------------------------------------------------------------------------
// xpt_sequencer
// Exception and bus-request sequencer. At each instruction boundary it picks
// BUSRQ, then a pending NMI, then an enabled maskable INT, and walks the
// acknowledge sequence for the winner: bus grant, NMI restart, or INT
// acknowledge in IM0, IM1 or IM2. It owns IFF1/IFF2 and the HALT latch.
// Ports:
//   clk  : core clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : xpt_sequencer_if.slave, which carries all request, strobe, done,
//          handshake and flag signals
// Outputs are registered and are decoded from the next state, so a state's
// request is valid right after the edge that enters that state.
// ---------------------------------------------------------------------------
module xpt_sequencer (
  input  logic            clk,
  input  logic            rst,
  xpt_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSGNT = 3'd1,
    ST_NMI_M1 = 3'd2,
    ST_PUSH   = 3'd3,
    ST_JUMP   = 3'd4,
    ST_INTACK = 3'd5,
    ST_VECRD  = 3'd6,
    ST_EXEC0  = 3'd7
  } state_t;

  // Records which sequence is in progress, so PUSH knows where to go next.
  typedef enum logic [1:0] {
    SRC_NMI = 2'd0,
    SRC_IM1 = 2'd1,
    SRC_IM2 = 2'd2
  } src_t;

  state_t      state_r,     state_nxt_s;
  src_t        src_r,       src_nxt_s;
  logic [15:0] jump_addr_r, jump_addr_nxt_s;
  logic [7:0]  op_byte_r,   op_byte_nxt_s;
  logic        iff1_r,      iff1_nxt_s;
  logic        iff2_r,      iff2_nxt_s;
  logic        halt_r,      halt_nxt_s;
  logic        ei_block_r,  ei_block_nxt_s;
  logic        nmi_pend_r,  nmi_pend_nxt_s;
  logic        nmi_prev_r;
  logic        nmi_accept_s;
  logic        int_accept_s;
  logic        busak_r, intack_r, push_req_r, vec_req_r;
  logic        jump_r, exec_op_r, busy_r;

  // Next-state, latched data, interrupt flags and NMI latch.
  always_comb begin
    state_nxt_s     = state_r;
    src_nxt_s       = src_r;
    jump_addr_nxt_s = jump_addr_r;
    op_byte_nxt_s   = op_byte_r;
    iff1_nxt_s      = iff1_r;
    iff2_nxt_s      = iff2_r;
    halt_nxt_s      = halt_r;
    ei_block_nxt_s  = ei_block_r;
    nmi_pend_nxt_s  = nmi_pend_r;
    nmi_accept_s    = 1'b0;
    int_accept_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.boundary) begin
          if (bus.BUSRQ) begin
            state_nxt_s = ST_BUSGNT;
          end else if (nmi_pend_r) begin
            state_nxt_s  = ST_NMI_M1;
            src_nxt_s    = SRC_NMI;
            nmi_accept_s = 1'b1;
          end else if (bus.INT && iff1_r && !ei_block_r) begin
            state_nxt_s  = ST_INTACK;
            int_accept_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSGNT: begin
        if (!bus.BUSRQ) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSGNT;
        end
      end
      ST_NMI_M1: begin
        // Dummy M1 cycle.
        state_nxt_s = ST_PUSH;
      end
      ST_PUSH: begin
        if (bus.push_done) begin
          if (src_r == SRC_IM2) begin
            state_nxt_s = ST_VECRD;
          end else begin
            state_nxt_s     = ST_JUMP;
            jump_addr_nxt_s = (src_r == SRC_NMI) ? 16'h0066 : 16'h0038;
          end
        end else begin
          state_nxt_s = ST_PUSH;
        end
      end
      ST_JUMP: begin
        state_nxt_s = ST_IDLE;
      end
      ST_INTACK: begin
        if (bus.ack_done) begin
          op_byte_nxt_s = bus.Din;
          case (bus.IM)
            2'd0: begin
              state_nxt_s = ST_EXEC0;
            end
            2'd1: begin
              state_nxt_s = ST_PUSH;
              src_nxt_s   = SRC_IM1;
            end
            default: begin
              // IM 3 behaves as IM2.
              state_nxt_s = ST_PUSH;
              src_nxt_s   = SRC_IM2;
            end
          endcase
        end else begin
          state_nxt_s = ST_INTACK;
        end
      end
      ST_VECRD: begin
        if (bus.vec_done) begin
          state_nxt_s     = ST_JUMP;
          jump_addr_nxt_s = bus.vec_data;
        end else begin
          state_nxt_s = ST_VECRD;
        end
      end
      ST_EXEC0: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Acceptance overrides any decode strobe that arrives in the same cycle.
    if (nmi_accept_s) begin
      iff1_nxt_s = 1'b0;
      halt_nxt_s = 1'b0;
    end else if (int_accept_s) begin
      iff1_nxt_s = 1'b0;
      iff2_nxt_s = 1'b0;
      halt_nxt_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      if (bus.ei_exec) begin
        iff1_nxt_s = 1'b1;
        iff2_nxt_s = 1'b1;
      end else if (bus.di_exec) begin
        iff1_nxt_s = 1'b0;
        iff2_nxt_s = 1'b0;
      end else if (bus.retn_exec) begin
        iff1_nxt_s = iff2_r;
      end else begin
        iff1_nxt_s = iff1_r;
      end
      if (bus.halt_exec) begin
        halt_nxt_s = 1'b1;
      end else begin
        halt_nxt_s = halt_r;
      end
    end else begin
      iff1_nxt_s = iff1_r;
    end

    // EI usually arrives together with its own boundary. Setting wins, so
    // the block survives until the boundary of the following instruction.
    if (state_r == ST_IDLE) begin
      if (bus.ei_exec) begin
        ei_block_nxt_s = 1'b1;
      end else if (bus.boundary) begin
        ei_block_nxt_s = 1'b0;
      end else begin
        ei_block_nxt_s = ei_block_r;
      end
    end else begin
      ei_block_nxt_s = ei_block_r;
    end

    // A fresh edge in the acceptance cycle keeps the latch set.
    if (bus.NMI && !nmi_prev_r) begin
      nmi_pend_nxt_s = 1'b1;
    end else if (nmi_accept_s) begin
      nmi_pend_nxt_s = 1'b0;
    end else begin
      nmi_pend_nxt_s = nmi_pend_r;
    end
  end

  // State, flags, latched data and registered request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      src_r       <= SRC_NMI;
      jump_addr_r <= 16'h0000;
      op_byte_r   <= 8'h00;
      iff1_r      <= 1'b0;
      iff2_r      <= 1'b0;
      halt_r      <= 1'b0;
      ei_block_r  <= 1'b0;
      nmi_pend_r  <= 1'b0;
      nmi_prev_r  <= 1'b0;
      busak_r     <= 1'b0;
      intack_r    <= 1'b0;
      push_req_r  <= 1'b0;
      vec_req_r   <= 1'b0;
      jump_r      <= 1'b0;
      exec_op_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      src_r       <= src_nxt_s;
      jump_addr_r <= jump_addr_nxt_s;
      op_byte_r   <= op_byte_nxt_s;
      iff1_r      <= iff1_nxt_s;
      iff2_r      <= iff2_nxt_s;
      halt_r      <= halt_nxt_s;
      ei_block_r  <= ei_block_nxt_s;
      nmi_pend_r  <= nmi_pend_nxt_s;
      nmi_prev_r  <= bus.NMI;
      busak_r     <= (state_nxt_s == ST_BUSGNT);
      intack_r    <= (state_nxt_s == ST_INTACK);
      push_req_r  <= (state_nxt_s == ST_PUSH);
      vec_req_r   <= (state_nxt_s == ST_VECRD);
      jump_r      <= (state_nxt_s == ST_JUMP);
      exec_op_r   <= (state_nxt_s == ST_EXEC0);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.BUSAK     = busak_r;
  assign bus.INTACK    = intack_r;
  assign bus.push_req  = push_req_r;
  assign bus.vec_req   = vec_req_r;
  // The IM2 table entry is word aligned, so bit 0 of the acknowledge byte is ignored.
  assign bus.vec_addr  = {bus.Ireg, op_byte_r[7:1], 1'b0};
  assign bus.jump      = jump_r;
  assign bus.jump_addr = jump_addr_r;
  assign bus.exec_op   = exec_op_r;
  assign bus.op_byte   = op_byte_r;
  assign bus.IFF1      = iff1_r;
  assign bus.IFF2      = iff2_r;
  assign bus.HALT      = halt_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_xpt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_xpt_sequencer
// Directed bench for xpt_sequencer. Inputs change 1 ns after a rising edge.
// Outputs are checked at that same point, after the edge has taken effect.
// ---------------------------------------------------------------------------
module tb_xpt_sequencer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  xpt_sequencer_if bus ();

  xpt_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one idle instruction with EI, then one plain boundary, so that IFF1=IFF2=1 and ei_block is clear.
  task automatic enable_ints();
    bus.ei_exec = 1'b1;
    step();
    bus.ei_exec  = 1'b0;
    bus.boundary = 1'b1;
    step();
    bus.boundary = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.boundary = 1'b0; bus.BUSRQ = 1'b0; bus.NMI = 1'b0; bus.INT = 1'b0;
    bus.IM = 2'd0; bus.Ireg = 8'h12;
    bus.ei_exec = 1'b0; bus.di_exec = 1'b0; bus.retn_exec = 1'b0; bus.halt_exec = 1'b0;
    bus.ack_done = 1'b0; bus.Din = 8'h00; bus.push_done = 1'b0;
    bus.vec_done = 1'b0; bus.vec_data = 16'h0000;
    step();
    step();

    // Reset values.
    check("rst_busak",    {31'd0, bus.BUSAK},    32'd0);
    check("rst_intack",   {31'd0, bus.INTACK},   32'd0);
    check("rst_push",     {31'd0, bus.push_req}, 32'd0);
    check("rst_jump",     {31'd0, bus.jump},     32'd0);
    check("rst_jaddr",    {16'd0, bus.jump_addr}, 32'h0000);
    check("rst_vaddr",    {16'd0, bus.vec_addr}, 32'h1200);
    check("rst_iff",      {30'd0, bus.IFF1, bus.IFF2}, 32'd0);
    check("rst_busy",     {31'd0, bus.busy},     32'd0);
    rst = 1'b0;
    step();

    // Reset in the middle of PUSH.
    bus.NMI = 1'b1;
    step();
    bus.boundary = 1'b1;
    step();
    bus.boundary = 1'b0;
    check("nmi_m1_busy",  {31'd0, bus.busy},     32'd1);
    step();
    check("mid_push_req", {31'd0, bus.push_req}, 32'd1);
    bus.NMI = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_push",    {31'd0, bus.push_req}, 32'd0);
    check("arst_busy",    {31'd0, bus.busy},     32'd0);
    step();
    check("arst_jump",    {31'd0, bus.jump},     32'd0);
    check("arst_iff",     {30'd0, bus.IFF1, bus.IFF2}, 32'd0);
    rst = 1'b0;
    step();

    // A BUSRQ that drops in the grant cycle gives a one-cycle BUSAK pulse.
    bus.BUSRQ = 1'b1; bus.boundary = 1'b1;
    step();
    bus.BUSRQ = 1'b0; bus.boundary = 1'b0;
    check("pulse_busak1", {31'd0, bus.BUSAK},    32'd1);
    step();
    check("pulse_busak0", {31'd0, bus.BUSAK},    32'd0);

    // BUSRQ beats NMI and INT, and the NMI is taken at the next boundary.
    enable_ints();
    bus.NMI = 1'b1;
    step();
    bus.BUSRQ = 1'b1; bus.INT = 1'b1; bus.boundary = 1'b1;
    step();
    bus.boundary = 1'b0;
    check("prio_busak",   {31'd0, bus.BUSAK},    32'd1);
    check("prio_intack",  {31'd0, bus.INTACK},   32'd0);
    step(); step(); step();
    check("hold_busak",   {31'd0, bus.BUSAK},    32'd1);
    bus.BUSRQ = 1'b0;
    step();
    check("drop_busak",   {31'd0, bus.BUSAK},    32'd0);
    check("drop_busy",    {31'd0, bus.busy},     32'd0);
    check("gnt_iff",      {30'd0, bus.IFF1, bus.IFF2}, 32'd3);
    bus.boundary = 1'b1;
    step();
    bus.boundary = 1'b0; bus.INT = 1'b0;
    check("nmi2_intack",  {31'd0, bus.INTACK},   32'd0);
    check("nmi2_busy",    {31'd0, bus.busy},     32'd1);
    check("nmi2_iff",     {30'd0, bus.IFF1, bus.IFF2}, 32'd1);
    step();
    check("nmi2_push",    {31'd0, bus.push_req}, 32'd1);
    bus.push_done = 1'b1;
    step();
    bus.push_done = 1'b0;
    check("nmi2_jump",    {31'd0, bus.jump},     32'd1);
    check("nmi2_jaddr",   {16'd0, bus.jump_addr}, 32'h0066);
    check("nmi2_pushlo",  {31'd0, bus.push_req}, 32'd0);
    step();
    check("nmi2_jumplo",  {31'd0, bus.jump},     32'd0);
    bus.NMI = 1'b0;

    // EI blocks INT at the following boundary only. IM1 path.
    bus.ei_exec = 1'b1;
    step();
    bus.ei_exec = 1'b0;
    check("ei_iff",       {30'd0, bus.IFF1, bus.IFF2}, 32'd3);
    bus.INT = 1'b1; bus.IM = 2'd1; bus.boundary = 1'b1;
    step();
    check("eiblk_intack", {31'd0, bus.INTACK},   32'd0);
    step();
    bus.boundary = 1'b0;
    check("int_intack",   {31'd0, bus.INTACK},   32'd1);
    check("int_iff",      {30'd0, bus.IFF1, bus.IFF2}, 32'd0);
    step();
    check("ack_wait",     {31'd0, bus.INTACK},   32'd1);
    bus.ack_done = 1'b1; bus.Din = 8'hAA;
    step();
    bus.ack_done = 1'b0; bus.INT = 1'b0;
    check("im1_intacklo", {31'd0, bus.INTACK},   32'd0);
    check("im1_push",     {31'd0, bus.push_req}, 32'd1);
    bus.push_done = 1'b1;
    step();
    bus.push_done = 1'b0;
    check("im1_jump",     {31'd0, bus.jump},     32'd1);
    check("im1_jaddr",    {16'd0, bus.jump_addr}, 32'h0038);
    step();
    check("im1_idle",     {31'd0, bus.busy},     32'd0);

    // NMI wakes HALT, keeps IFF2, then RETN restores IFF1.
    enable_ints();
    bus.halt_exec = 1'b1;
    step();
    bus.halt_exec = 1'b0;
    check("halt_set",     {31'd0, bus.HALT},     32'd1);
    bus.NMI = 1'b1;
    step();
    bus.boundary = 1'b1;
    step();
    bus.boundary = 1'b0;
    check("nmi_halt",     {31'd0, bus.HALT},     32'd0);
    check("nmi_iff",      {30'd0, bus.IFF1, bus.IFF2}, 32'd1);
    step();
    check("nmi_push",     {31'd0, bus.push_req}, 32'd1);
    step();
    check("nmi_pushhold", {31'd0, bus.push_req}, 32'd1);
    bus.push_done = 1'b1;
    step();
    bus.push_done = 1'b0; bus.NMI = 1'b0;
    check("nmi_jump",     {31'd0, bus.jump},     32'd1);
    check("nmi_jaddr",    {16'd0, bus.jump_addr}, 32'h0066);
    step();
    bus.retn_exec = 1'b1;
    step();
    bus.retn_exec = 1'b0;
    check("retn_iff",     {30'd0, bus.IFF1, bus.IFF2}, 32'd3);

    // IM2 vectored interrupt.
    enable_ints();
    bus.IM = 2'd2; bus.Ireg = 8'h12; bus.INT = 1'b1; bus.boundary = 1'b1;
    step();
    bus.boundary = 1'b0;
    check("im2_intack",   {31'd0, bus.INTACK},   32'd1);
    bus.ack_done = 1'b1; bus.Din = 8'h35;
    step();
    bus.ack_done = 1'b0; bus.INT = 1'b0;
    check("im2_vaddr",    {16'd0, bus.vec_addr}, 32'h1234);
    check("im2_push",     {31'd0, bus.push_req}, 32'd1);
    bus.push_done = 1'b1;
    step();
    bus.push_done = 1'b0;
    check("im2_vecreq",   {31'd0, bus.vec_req},  32'd1);
    check("im2_pushlo",   {31'd0, bus.push_req}, 32'd0);
    bus.vec_done = 1'b1; bus.vec_data = 16'hBEEF;
    step();
    bus.vec_done = 1'b0; bus.vec_data = 16'h0000;
    check("im2_jump",     {31'd0, bus.jump},     32'd1);
    check("im2_jaddr",    {16'd0, bus.jump_addr}, 32'hBEEF);
    check("im2_veclo",    {31'd0, bus.vec_req},  32'd0);
    step();
    check("im2_jumplo",   {31'd0, bus.jump},     32'd0);

    // IM0 executes the acknowledge byte and does no push.
    enable_ints();
    bus.IM = 2'd0; bus.INT = 1'b1; bus.boundary = 1'b1;
    step();
    bus.boundary = 1'b0;
    check("im0_intack",   {31'd0, bus.INTACK},   32'd1);
    bus.ack_done = 1'b1; bus.Din = 8'hFF;
    step();
    bus.ack_done = 1'b0; bus.INT = 1'b0;
    check("im0_exec",     {31'd0, bus.exec_op},  32'd1);
    check("im0_opbyte",   {24'd0, bus.op_byte},  32'h00FF);
    check("im0_nopush",   {31'd0, bus.push_req}, 32'd0);
    step();
    check("im0_execlo",   {31'd0, bus.exec_op},  32'd0);
    check("im0_idle",     {31'd0, bus.busy},     32'd0);
    check("im0_nojump",   {31'd0, bus.jump},     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
